// File: rtl/uart_arb_pkg.sv
// Shared constants and state encodings for the UART TX arbiter.
// One-hot FSM states; ST_HOLD is only reachable when the lock path is built.
package uart_arb_pkg;

  localparam int DATA_W        = 8;
  localparam int LOCK_IDLE_CYC = 16;

  typedef enum logic [5:0] {
    ST_IDLE      = 6'b000001,
    ST_LOAD      = 6'b000010,
    ST_START     = 6'b000100,
    ST_WAIT_DONE = 6'b001000,
    ST_RELEASE   = 6'b010000,
    ST_HOLD      = 6'b100000
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after the
// pointer, wrapping modulo NUM_REQ.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any_valid
);

  always_comb begin
    int j;
    j           = 0;
    o_winner    = '0;
    o_any_valid = 1'b0;
    // walk from the far end so the nearest valid slot wins last
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(i_rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (i_req_valid[IDX_W'(j)]) begin
        o_winner    = IDX_W'(j);
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX core between NUM_REQ byte producers.
// Optional UART_ARB_LOCK_EN adds req_last for multi-byte locked bursts.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int IDX_W       = 2
) (
  input  logic                      clk,
  input  logic                      rst_count,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_last,
`endif
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

  state_t             r_state;
  state_t             w_state_nx;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic [DATA_W-1:0]  r_data;
  logic [TMR_W-1:0]   r_timer;
  logic               r_err;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_acc_idx;
  logic [IDX_W-1:0]   w_next_ptr;
  logic               w_any;
  logic               w_accept;
  logic               w_adv;
  logic               w_set_err;
  logic               w_tmr_clr;
  logic               w_tmo;
  logic               w_lock_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_ptr),
    .o_winner    (w_win),
    .o_any_valid (w_any)
  );

  assign w_next_ptr = (r_grant == IDX_W'(NUM_REQ - 1)) ?
                      '0 : r_grant + IDX_W'(1);
  assign w_tmo      = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

`ifdef UART_ARB_LOCK_EN
  localparam int IDLE_W = $clog2(LOCK_IDLE_CYC);

  logic              r_last;
  logic [IDLE_W-1:0] r_idle;

  assign w_lock_end = r_last;

  always_ff @(posedge clk or negedge rst_count) begin
    if (!rst_count) begin
      r_last <= 1'b1;
      r_idle <= '0;
    end else begin
      if (w_accept)       r_last <= req_last[w_acc_idx];
      else if (w_set_err) r_last <= 1'b1;
      if (r_state == ST_HOLD && !req_valid[r_grant])
        r_idle <= r_idle + IDLE_W'(1);
      else
        r_idle <= '0;
    end
  end
`else
  assign w_lock_end = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_count) begin
    if (!rst_count) r_state <= ST_IDLE;
    else            r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_acc_idx  = w_win;
    w_adv      = 1'b0;
    w_set_err  = 1'b0;
    w_tmr_clr  = 1'b0;
    unique case (1'b1)
      (r_state == ST_IDLE): begin
        if (w_any && rst_count) begin
          w_accept   = 1'b1;
          w_state_nx = ST_LOAD;
        end
      end
      (r_state == ST_LOAD): w_state_nx = ST_START;
      (r_state == ST_START): begin
        w_tmr_clr  = 1'b1;
        w_state_nx = ST_WAIT_DONE;
      end
      (r_state == ST_WAIT_DONE): begin
        if (tx_done) begin
          w_adv      = w_lock_end;
          w_state_nx = ST_RELEASE;
        end else if (w_tmo) begin
          w_set_err  = 1'b1;
          w_adv      = 1'b1;
          w_state_nx = ST_RELEASE;
        end
      end
      (r_state == ST_RELEASE): begin
        if (!tx_done)
          w_state_nx = w_lock_end ? ST_IDLE : ST_HOLD;
      end
`ifdef UART_ARB_LOCK_EN
      (r_state == ST_HOLD): begin
        w_acc_idx = r_grant;
        if (req_valid[r_grant] && rst_count) begin
          w_accept   = 1'b1;
          w_state_nx = ST_LOAD;
        end else if (r_idle == IDLE_W'(LOCK_IDLE_CYC - 1)) begin
          w_adv      = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
`endif
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_count) begin
    if (!rst_count) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_data  <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant <= w_acc_idx;
        r_data  <= req_data[int'(w_acc_idx)*DATA_W +: DATA_W];
      end
      // timer saturates rather than wrapping
      if (w_tmr_clr)
        r_timer <= '0;
      else if (r_state == ST_WAIT_DONE && r_timer != '1)
        r_timer <= r_timer + TMR_W'(1);
      if (w_adv)     r_ptr <= w_next_ptr;
      if (w_set_err) r_err <= 1'b1;
    end
  end

  assign req_ready   = w_accept ?
                       (NUM_REQ'(1) << w_acc_idx) : '0;
  assign tx_start    = (r_state == ST_START);
  assign tx_data     = r_data;
  assign grant_idx   = r_grant;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-cycle transaction model plus directed
// literal checks; producers and TX core are simple behavioural mocks.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 20;

  logic           clk = 1'b0;
  logic           rst_count = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_done = 1'b0;
  logic [1:0]     grant_idx;
  logic           busy;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (TMO),
    .IDX_W       (2)
  ) dut (
    .clk         (clk),
    .rst_count   (rst_count),
    .req_valid   (req_valid),
    .req_data    (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_last    ('1),
`endif
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, got, exp, $time);
  endtask

  // producers: per-requester byte FIFOs
  logic [7:0] mem [N][32];
  int head [N];
  int tail [N];

  task automatic push(input int i, input logic [7:0] b);
    mem[i][tail[i]] = b;
    tail[i]++;
  endtask

  // TX core mock
  int cnt = 0, hi = 0, dly = 2, len = 1, cyc = 0;
  bit no_done = 1'b0, force_done = 1'b0;
  logic [N-1:0] hs = '0;
  bit st_seen = 1'b0;
  int order[$];
  int st_cyc[$];

  always @(negedge clk) begin
    hs      = req_valid & req_ready;
    st_seen = tx_start;
    if (st_seen) st_cyc.push_back(cyc);
    for (int i = 0; i < N; i++) if (hs[i]) order.push_back(i);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) head[i]++;
        req_valid[i] = head[i] < tail[i];
        req_data[8*i +: 8] = (head[i] < tail[i]) ? mem[i][head[i]] : 8'h00;
      end
      if (st_seen && !no_done) cnt = dly;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) hi = len;
      end
      if (!rst_count) begin
        cnt = 0;
        hi  = 0;
      end
      tx_done = (hi > 0) || force_done;
      if (hi > 0) hi--;
    end
  end

  // transaction-level model: age counts cycles since acceptance
  bit         m_busy, m_rel, m_err;
  int         m_age, m_gidx, m_ptr;
  logic [7:0] m_byte;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] e_rdy;
    int w;
    e_rdy = '0;
    w = -1;
    if (!rst_count) begin
      check("rst_ready", req_ready, 0);
      check("rst_start", tx_start, 0);
      check("rst_data", tx_data, 0);
      check("rst_grant", grant_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_err", timeout_err, 0);
      m_busy = 0; m_rel = 0; m_err = 0;
      m_age = 0; m_gidx = 0; m_ptr = 0; m_byte = 8'h00;
    end else begin
      if (!m_busy) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) e_rdy[w] = 1'b1;
      end
      check("cyc_ready", req_ready, e_rdy);
      check("cyc_start", tx_start, m_busy && m_age == 2);
      check("cyc_data", tx_data, m_byte);
      check("cyc_grant", grant_idx, m_gidx);
      check("cyc_busy", busy, m_busy);
      check("cyc_err", timeout_err, m_err);
      if (tx_start) check("start_vs_done", tx_done, 0);
      if (!m_busy) begin
        if (w >= 0) begin
          m_busy = 1; m_age = 1; m_gidx = w;
          m_byte = req_data[8*w +: 8];
        end
      end else if (m_rel) begin
        if (!tx_done) begin
          m_busy = 0;
          m_rel  = 0;
        end
      end else if (m_age < 3) begin
        m_age++;
      end else if (tx_done) begin
        m_rel = 1;
        m_ptr = (m_gidx + 1) % N;
      end else if (m_age - 2 == TMO) begin
        m_err = 1;
        m_rel = 1;
        m_ptr = (m_gidx + 1) % N;
      end else begin
        m_age++;
      end
    end
  end

  task automatic wait_quiet(input string name, input int budget);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while ((busy || req_valid != 0) && k < budget);
    check(name, busy || req_valid != 0, 0);
  endtask

  task automatic wait_start(input string name, input int budget);
    int k;
    k = 0;
    while (!tx_start && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    check(name, tx_start, 1);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #2;
    check("r0_ready", req_ready, 0);
    check("r0_data", tx_data, 0);
    check("r0_grant", grant_idx, 0);
    check("r0_busy", busy, 0);
    rst_count = 1'b1;

    // single request
    dly = 3; len = 1;
    @(negedge clk); #1;
    push(1, 8'hA5);
    @(posedge clk); #2;
    check("t1_ready", req_ready, 4'b0010);
    @(posedge clk); #2;
    check("t1_load_start", tx_start, 0);
    check("t1_data", tx_data, 8'hA5);
    check("t1_grant", grant_idx, 1);
    @(posedge clk); #2;
    check("t1_start", tx_start, 1);
    wait_quiet("t1_quiet", 60);

    // round robin from pointer 0
    @(posedge clk); #2 rst_count = 1'b0;
    @(posedge clk); #2 rst_count = 1'b1;
    dly = 2; len = 1;
    order.delete();
    @(negedge clk); #1;
    push(0, 8'h10); push(0, 8'h11);
    push(1, 8'h21); push(2, 8'h32); push(3, 8'h43);
    wait_quiet("t2_quiet", 200);
    check("t2_count", order.size(), 5);
    if (order.size() == 5) begin
      check("t2_g0", order[0], 0);
      check("t2_g1", order[1], 1);
      check("t2_g2", order[2], 2);
      check("t2_g3", order[3], 3);
      check("t2_g4", order[4], 0);
    end

    // tx_done held high for 5 cycles
    dly = 2; len = 5;
    st_cyc.delete();
    @(negedge clk); #1;
    push(2, 8'h5A); push(2, 8'h5B);
    wait_quiet("t3_quiet", 100);
    check("t3_starts", st_cyc.size(), 2);
    if (st_cyc.size() == 2)
      check("t3_gap", st_cyc[1] - st_cyc[0], 10);

    // timeout, then next requester served
    no_done = 1'b1; len = 1;
    @(negedge clk); #1;
    push(3, 8'h3C); push(0, 8'h0F);
    @(posedge clk); #2;
    wait_start("t4_start", 20);
    k = 0;
    while (!timeout_err && k < 40) begin
      @(posedge clk); #2;
      k++;
    end
    check("t4_tmo_cyc", k, TMO + 1);
    check("t4_grant", grant_idx, 3);
    no_done = 1'b0; dly = 2;
    wait_quiet("t4_quiet", 100);
    check("t4_next", grant_idx, 0);
    check("t4_sticky", timeout_err, 1);

    // reset during WAIT_DONE
    dly = 10;
    @(negedge clk); #1;
    push(1, 8'h77);
    @(posedge clk); #2;
    wait_start("t5_start", 20);
    repeat (2) @(posedge clk);
    #2 rst_count = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_err", timeout_err, 0);
    check("t5_data", tx_data, 0);
    check("t5_grant", grant_idx, 0);
    check("t5_start", tx_start, 0);
    check("t5_ready", req_ready, 0);
    @(posedge clk); #2 rst_count = 1'b1;

    // tx_done while idle is ignored
    force_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("t6_idle_done", busy, 0);
    force_done = 1'b0;
    dly = 2;
    @(negedge clk); #1;
    push(3, 8'h99); push(2, 8'hC2);
    wait_quiet("t6_quiet", 100);
    check("t6_first", order[order.size()-2], 2);
    check("t6_second", order[order.size()-1], 3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter core between NUM_REQ byte producers using round-robin arbitration. The block latches the granted byte and issues a single-cycle tx_start. It holds tx_data stable until the core reports tx_done, then waits for tx_done to drop before re-arbitrating. It sits between the requesting blocks (command parser, status reporter, loopback) and the TX core, in the clk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 200000, clk cycles allowed from tx_start to tx_done before abort
IDX_W, 2, width of grant index (must equal clog2(NUM_REQ))

Ports:
clk  in  1  system clock
rst_count  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  flattened bytes; requester i at bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot, single-cycle accept pulse
tx_start  out  1  start pulse to TX core
tx_data  out  8  byte to TX core
tx_done  in  1  TX core completion (level, may stay high several cycles)
grant_idx  out  IDX_W  index of current/last granted requester
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset (rst_count=0, async): state=IDLE; req_ready=0; tx_start=0; tx_data=8'h00; grant_idx=0; busy=0; timeout_err=0; rr pointer=0; timer=0.
- States: IDLE, LOAD, START, WAIT_DONE, RELEASE, one-hot encoded.
- IDLE: if any req_valid, select the first set bit at or after rr_ptr, wrapping modulo NUM_REQ. Register grant_idx. Latch req_data of the winner into tx_data. Pulse req_ready[winner] for exactly this cycle. Go to LOAD. If no req_valid, stay in IDLE.
- Handshake: a byte is transferred on the cycle req_valid[i]=1 and req_ready[i]=1. Requesters must hold data stable while valid. Dropping valid before ready is allowed and cancels the request with no effect.
- LOAD: one cycle that lets tx_data settle. Go to START.
- START: tx_start=1 for exactly one cycle. Clear the timer. Go to WAIT_DONE.
- WAIT_DONE: tx_data is held and the timer increments each cycle.
  - tx_done=1: go to RELEASE; rr_ptr = grant_idx+1 (wraps).
  - timer == TIMEOUT_CYC-1: set timeout_err; rr_ptr = grant_idx+1; go to RELEASE.
- RELEASE: wait until tx_done=0, then go to IDLE. Minimum one cycle.
- Latency: req_valid seen in IDLE at cycle n -> req_ready at n, tx_start at n+2.
- Simultaneous requests: exactly one winner per arbitration. Losers keep valid and are served in rotation. Each requester is guaranteed service within NUM_REQ transfers.
- tx_done high while in IDLE, LOAD or START is ignored and not counted.
- Mid-operation reset: everything returns to reset values immediately. An accepted but unsent byte is dropped.
- Wrap-around: with grant_idx=NUM_REQ-1, rr_ptr becomes 0. The timer saturates and never wraps.
- tx_start is never asserted again before tx_done has deasserted.

Optional Feature:
UART_ARB_LOCK_EN
- Defined: adds input req_last [NUM_REQ]. After a transfer where req_last[grant]=0, RELEASE goes to a HOLD path that keeps the grant on the same requester and skips arbitration. Other requesters are blocked until a byte with req_last=1 completes, or until the locked requester drops valid for 16 consecutive cycles (lock abandoned). rr_ptr advances only when the lock ends.
- Undefined: no req_last port; every byte is arbitrated independently.

Decomposition:
- Package uart_arb_pkg: state encodings (ST_IDLE..ST_RELEASE one-hot constants), DATA_W=8, LOCK_IDLE_CYC=16.
- Sub-module rr_pick: combinational round-robin selector. Inputs req_valid and rr_ptr; outputs winner index and any_valid. The FSM, timer and registers stay in the top.

Test Plan:
- Single request: req_valid=4'b0010, data1=8'hA5 -> req_ready=4'b0010 for 1 cycle, tx_start 2 cycles later, tx_data=8'hA5 until tx_done, grant_idx=1.
- All four valid continuously, rr_ptr=0 -> grant order 0,1,2,3,0; each requester sees exactly one ready pulse per round.
- tx_done held high 5 cycles -> exactly one arbitration after it falls; no second tx_start while tx_done=1.
- TIMEOUT_CYC=20, tx_done never asserted -> timeout_err=1 at START+20 cycles, block returns to IDLE, next requester is served.
- Assert rst_count=0 during WAIT_DONE -> all outputs at reset values within the same cycle, busy=0, timeout_err=0.
- With UART_ARB_LOCK_EN: requester 2 sends 3 bytes (last on the 3rd) while requester 0 is valid -> bytes 2,2,2 then 0.
